// File: rtl/baud_cfg_ctrl.sv
// baud_cfg_ctrl: programs the 16-bit baud divisor (DB low then high byte),
// then verifies that the baud generator's enable pulses arrive every div+1
// cycles. Reports busy / ready / err and reprograms on request, on a baud
// select change, or after reset.
`timescale 1ns/1ps
module baud_cfg_ctrl #(
    parameter logic [15:0] DIV_0   = 16'h028A,
    parameter logic [15:0] DIV_1   = 16'h0145,
    parameter logic [15:0] DIV_2   = 16'h00A2,
    parameter logic [15:0] DIV_3   = 16'h0050,
    parameter logic [16:0] TIMEOUT = 17'd65540
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  br_cfg,
    input  logic        cfg_req,
    input  logic        baud_en,
    output logic [1:0]  ioaddr,
    output logic [7:0]  databus,
    output logic [15:0] cur_div,
    output logic        busy,
    output logic        ready,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_LO   = 3'd1,
        WR_HI   = 3'd2,
        WAIT_EN = 3'd3,
        MEASURE = 3'd4,
        READY   = 3'd5,
        ERR     = 3'd6
    } state_t;

    state_t      state, state_nxt;
    logic [16:0] cnt, cnt_nxt, cnt_inc;
    logic        pend, pend_nxt;
    logic        err_nxt;
    logic [1:0]  br_q;
    logic        trig;
    logic [15:0] div_sel;
    logic [16:0] div_ext;

    // Divisor selected by the current baud select
    always_comb begin
        div_sel = DIV_0;
        case (br_cfg)
            2'b00: div_sel = DIV_0;
            2'b01: div_sel = DIV_1;
            2'b10: div_sel = DIV_2;
            2'b11: div_sel = DIV_3;
            default: div_sel = DIV_0;
        endcase
    end

    // A restart is requested explicitly or implied by a new baud select
    assign trig    = cfg_req | (br_cfg != br_q);
    assign div_ext = {1'b0, cur_div};
    // Saturating so a stuck counter can never wrap into a false match
    assign cnt_inc = (cnt == 17'h1FFFF) ? cnt : cnt + 17'd1;

    // Next-state, counter, pending-restart and error decisions
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        pend_nxt  = pend;
        err_nxt   = err;
        case (state)
            IDLE: begin
                state_nxt = WR_LO;
            end
            WR_LO: begin
                pend_nxt  = pend | trig;
                state_nxt = WR_HI;
            end
            WR_HI: begin
                pend_nxt  = pend | trig;
                state_nxt = WAIT_EN;
                cnt_nxt   = '0;
            end
            WAIT_EN: begin
                pend_nxt = pend | trig;
                if (baud_en) begin
                    state_nxt = MEASURE;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= TIMEOUT) begin
                    state_nxt = ERR;
                    err_nxt   = 1'b1;
                end
            end
            MEASURE, READY: begin
                if (state == READY && (trig || pend)) begin
                    state_nxt = WR_LO;
                end else begin
                    // A restart seen during MEASURE waits until the verdict is shown
                    if (state == MEASURE)
                        pend_nxt = pend | trig;
                    if (baud_en) begin
                        cnt_nxt = '0;
                        if (cnt == div_ext) begin
                            state_nxt = READY;
                        end else begin
                            state_nxt = ERR;
                            err_nxt   = 1'b1;
                        end
                    end else if (cnt == div_ext) begin
                        // Pulse overdue: period would exceed div+1
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            ERR: begin
                if (trig || pend)
                    state_nxt = WR_LO;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Every entry into WR_LO starts a fresh programming attempt
        if (state_nxt == WR_LO) begin
            err_nxt  = 1'b0;
            pend_nxt = 1'b0;
        end
    end

    // State, counter and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= 1'b0;
            err     <= 1'b0;
            br_q    <= 2'b00;
            cur_div <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            err   <= err_nxt;
            br_q  <= br_cfg;
            if (state_nxt == WR_LO)
                cur_div <= div_sel;
        end
    end

    // Bus drive only during the two write cycles; status decoded from state
    always_comb begin
        ioaddr  = 2'b00;
        databus = 8'h00;
        case (state)
            WR_LO: begin
                ioaddr  = 2'b10;
                databus = cur_div[7:0];
            end
            WR_HI: begin
                ioaddr  = 2'b11;
                databus = cur_div[15:8];
            end
            default: ;
        endcase
        busy  = (state == WR_LO) || (state == WR_HI) ||
                (state == WAIT_EN) || (state == MEASURE);
        ready = (state == READY);
    end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Bench for baud_cfg_ctrl: directed scenarios plus randomized enable timing,
// every cycle compared against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_baud_cfg_ctrl;

    localparam int TMO = 65540;

    localparam int P_IDLE  = 0;
    localparam int P_LO    = 1;
    localparam int P_HI    = 2;
    localparam int P_WAIT  = 3;
    localparam int P_MEAS  = 4;
    localparam int P_READY = 5;
    localparam int P_ERR   = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  br_cfg;
    logic        cfg_req;
    logic        baud_en;
    logic [1:0]  ioaddr;
    logic [7:0]  databus;
    logic [15:0] cur_div;
    logic        busy, ready, err;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int   m_phase, m_div, m_anchor, m_cyc;
    bit   m_err, m_pend;
    logic [1:0] m_prev_br;

    // enable generator
    int en_mode;     // 0 off, 1 fixed period, 2 randomized around div+1
    int en_period;
    int gap_left;
    bit en_seen;

    baud_cfg_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .br_cfg  (br_cfg),
        .cfg_req (cfg_req),
        .baud_en (baud_en),
        .ioaddr  (ioaddr),
        .databus (databus),
        .cur_div (cur_div),
        .busy    (busy),
        .ready   (ready),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int div_of(input logic [1:0] b);
        case (b)
            2'd0: return 32'h028A;
            2'd1: return 32'h0145;
            2'd2: return 32'h00A2;
            default: return 32'h0050;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_div = 0; m_err = 0; m_pend = 0;
        m_prev_br = 2'b00; m_anchor = 0; m_cyc = 0;
    endtask

    task automatic go_lo();
        m_phase = P_LO; m_div = div_of(br_cfg); m_err = 0; m_pend = 0;
    endtask

    task automatic fault();
        m_phase = P_ERR; m_err = 1;
    endtask

    // One clock of the reference: elapsed time since the last anchor point
    // (start of wait or last accepted pulse) decides every verdict.
    task automatic model_step();
        bit trig;
        int el;
        trig = cfg_req || (br_cfg != m_prev_br);
        m_prev_br = br_cfg;
        el = m_cyc - m_anchor;
        case (m_phase)
            P_IDLE: go_lo();
            P_LO: begin m_pend |= trig; m_phase = P_HI; end
            P_HI: begin m_pend |= trig; m_phase = P_WAIT; m_anchor = m_cyc + 1; end
            P_WAIT: begin
                m_pend |= trig;
                if (baud_en) begin m_phase = P_MEAS; m_anchor = m_cyc + 1; end
                else if (el == TMO - 1) fault();
            end
            P_MEAS, P_READY: begin
                if (m_phase == P_READY && (trig || m_pend)) go_lo();
                else begin
                    if (m_phase == P_MEAS) m_pend |= trig;
                    if (baud_en) begin
                        if (el == m_div) begin m_phase = P_READY; m_anchor = m_cyc + 1; end
                        else fault();
                    end else if (el == m_div) fault();
                end
            end
            P_ERR: if (trig || m_pend) go_lo();
            default: ;
        endcase
        m_cyc++;
    endtask

    function automatic logic [31:0] exp_outs();
        logic [1:0]  ea;
        logic [7:0]  ed;
        logic [15:0] dv;
        dv = m_div[15:0];
        ea = 2'b00; ed = 8'h00;
        if (m_phase == P_LO) begin ea = 2'b10; ed = dv[7:0]; end
        if (m_phase == P_HI) begin ea = 2'b11; ed = dv[15:8]; end
        return {3'b0, ea, ed, dv, (m_phase >= P_LO && m_phase <= P_MEAS),
                (m_phase == P_READY), m_err};
    endfunction

    function automatic int pick_gap();
        int base;
        if (en_mode == 1) return en_period;
        base = div_of(br_cfg) + 1;
        if ($urandom_range(0, 9) < 8) return base;
        base = base + $urandom_range(0, 6) - 3;
        return (base < 1) ? 1 : base;
    endfunction

    task automatic drive_en();
        if (en_mode == 0) baud_en = 1'b0;
        else if (gap_left <= 0) begin baud_en = 1'b1; gap_left = pick_gap() - 1; end
        else begin baud_en = 1'b0; gap_left--; end
    endtask

    task automatic step();
        @(posedge clk);
        en_seen = baud_en;
        if (rst_n) model_step(); else model_reset();
        @(negedge clk);
        chk("outs", {3'b0, ioaddr, databus, cur_div, busy, ready, err}, exp_outs());
        drive_en();
    endtask

    task automatic pulse_req();
        cfg_req = 1'b1;
        step();
        cfg_req = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int bound);
        int n;
        n = 0;
        while (!ready && n < bound) begin step(); n++; end
        chk(tag, {31'b0, ready}, 32'd1);
    endtask

    task automatic wait_hi(input string tag);
        int n;
        n = 0;
        while (ioaddr != 2'b11 && n < 8) begin step(); n++; end
        chk(tag, {30'b0, ioaddr}, 32'd3);
    endtask

    initial begin
        int n, lo_cnt;
        rst_n = 1'b0; br_cfg = 2'b01; cfg_req = 1'b0; baud_en = 1'b0;
        en_mode = 1; en_period = 326; gap_left = 100;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset", {3'b0, ioaddr, databus, cur_div, busy, ready, err}, exp_outs());
        chk("reset_zero", {3'b0, ioaddr, databus, cur_div, busy, ready, err}, 32'd0);

        // T1: program 0x0145 after reset, become ready on correct period
        rst_n = 1'b1;
        step();
        chk("t1_lo", {22'b0, ioaddr, databus}, {22'b0, 2'b10, 8'h45});
        step();
        chk("t1_hi", {22'b0, ioaddr, databus}, {22'b0, 2'b11, 8'h01});
        step();
        chk("t1_idle_bus", {22'b0, ioaddr, databus}, 32'd0);
        wait_ready("t1_ready", 1200);
        chk("t1_div", {16'b0, cur_div}, 32'h0145);

        // T2: baud select change while ready
        br_cfg = 2'b11; en_period = 81; gap_left = 40;
        step();
        chk("t2_lo", {22'b0, ioaddr, databus}, {22'b0, 2'b10, 8'h50});
        step();
        chk("t2_hi", {22'b0, ioaddr, databus}, {22'b0, 2'b11, 8'h00});
        wait_ready("t2_ready", 400);
        chk("t2_div", {16'b0, cur_div}, 32'h0050);

        // T3: wrong period -> err, request clears err on WR_LO
        br_cfg = 2'b01; en_period = 300;
        pulse_req();
        n = 0;
        while (!err && n < 1500) begin step(); n++; end
        chk("t3_err", {30'b0, err, ready}, 32'd2);
        pulse_req();
        chk("t3_clr", {29'b0, err, ioaddr}, 32'd2);

        // T4: no pulses at all -> timeout after WR_HI plus TMO waiting cycles
        en_mode = 0;
        wait_hi("t4_hi");
        n = 0;
        while (!err && n < TMO + 10) begin step(); n++; end
        chk("t4_timeout", n, TMO + 1);
        chk("t4_state", {28'b0, ioaddr, busy, ready}, 32'd0);

        // T5: request during MEASURE -> verdict shown, then one rewrite
        en_mode = 1; en_period = 326; gap_left = 50;
        pulse_req();
        wait_hi("t5_hi");
        step();
        n = 0;
        while (!en_seen && n < 400) begin step(); n++; end
        chk("t5_meas", {31'b0, en_seen}, 32'd1);
        repeat (100) step();
        pulse_req();
        lo_cnt = 0;
        for (int i = 0; i < 1300; i++) begin
            step();
            if (ioaddr == 2'b10) lo_cnt++;
        end
        chk("t5_one_rewrite", lo_cnt, 1);
        chk("t5_ready", {31'b0, ready}, 32'd1);

        // T6: reset during WR_HI, full rewrite after release
        br_cfg = 2'b10;
        wait_hi("t6_hi");
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst", {29'b0, ioaddr, busy}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("t6_lo", {22'b0, ioaddr, databus}, {22'b0, 2'b10, 8'hA2});
        step();
        chk("t6_hi2", {22'b0, ioaddr, databus}, {22'b0, 2'b11, 8'h00});

        // Randomized pulse timing, requests and select changes
        en_mode = 2;
        for (int i = 0; i < 6000; i++) begin
            cfg_req = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 599) == 0) br_cfg = 2'($urandom_range(0, 3));
            step();
        end
        cfg_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
